// File: rtl/mux8_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux8_arbiter_pkg
// Shared types and constants for the round-robin arbiter that owns the 8:1
// single-bit select path (mux8_1) of the MIPS datapath.
//   N_REQ / IDX_W : requester count and the width of a requester index
//   CNT_W         : width of the hold counter (covers hold limits up to 255)
//   state_t       : arbiter FSM encoding (ST_IDLE / ST_OWN)
//   onehot()      : index -> one-hot grant vector
// -----------------------------------------------------------------------------
package mux8_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic req_vec_t onehot(input idx_t idx);
    onehot = req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux8_arbiter_if
// Bundle of the requester-facing and mux-facing signals of mux8_arbiter.
//   req[7:0]   : per-requester level request        (requester -> arbiter)
//   done       : current owner has finished         (requester -> arbiter)
//   grant[7:0] : one-hot grant, zero when no owner  (arbiter -> requesters)
//   select[2:0]: mux select, index of the owner     (arbiter -> mux8_1)
//   busy       : a grant is currently held          (arbiter -> system)
//   timeout    : one-cycle pulse on forced release  (arbiter -> system)
// Modports: master = requester pool side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mux8_arbiter_if;
  import mux8_arbiter_pkg::*;

  req_vec_t req;
  logic     done;
  req_vec_t grant;
  idx_t     select;
  logic     busy;
  logic     timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  select,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output select,
    output busy,
    output timeout
  );

endinterface

// File: rtl/mux8_arbiter_rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Purely combinational round-robin picker: returns the first set bit of req
// scanning circularly from ptr (ptr, ptr+1, ..., ptr+7 mod 8).
//   req[7:0] : candidate requests
//   ptr[2:0] : highest-priority position
//   found    : at least one request is set
//   idx[2:0] : chosen index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick8
  import mux8_arbiter_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     ptr,
  output logic     found,
  output idx_t     idx
);

  // rot[k] is the request at circular distance k from ptr, so the lowest set
  // bit of rot is the winner and its position is the offset to add back.
  req_vec_t rot;
  idx_t     offset;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ptr + idx_t'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    // Descending loop: the last hit written is the lowest set position.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = idx_t'(k);
      end
    end
  end

  assign found = |req;
  assign idx   = found ? (ptr + offset) : '0;

endmodule

// File: rtl/mux8_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_arbiter
// Round-robin arbiter/sequencer for the shared 8:1 select path. One requester
// owns the mux at a time; the grant is held until the owner signals done,
// drops its request, or reaches MAX_HOLD cycles, after which priority rotates
// so the served requester becomes the lowest priority.
//   MAX_HOLD : cycles a grant may be held before forced release (0 = no limit,
//              legal range 0..255)
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : mux8_arbiter_if.slave (req, done in; grant, select, busy,
//              timeout out -- all outputs registered)
// -----------------------------------------------------------------------------
module mux8_arbiter
  import mux8_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mux8_arbiter_if.slave  bus
);

  // Hold limit: release happens on the OWN cycle where the counter shows
  // MAX_HOLD-1, so the grant is visible for exactly MAX_HOLD cycles.
  localparam bit   HOLD_EN   = (MAX_HOLD != 0);
  localparam cnt_t HOLD_LAST = (MAX_HOLD == 0) ? cnt_t'(0) : cnt_t'(MAX_HOLD - 1);
  localparam cnt_t CNT_MAX   = '1;

  state_t   state_reg,    state_next;
  idx_t     ptr_reg,      ptr_next;
  cnt_t     hold_cnt_reg, hold_cnt_next;
  req_vec_t grant_reg,    grant_next;
  idx_t     select_reg,   select_next;
  logic     busy_reg,     busy_next;
  logic     timeout_reg,  timeout_next;

  logic     pick_found;
  idx_t     pick_idx;

  // Release causes while owning.
  logic     rel_done;
  logic     rel_withdraw;
  logic     rel_limit;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rel_done     = bus.done;
  assign rel_withdraw = ~bus.req[select_reg];
  assign rel_limit    = HOLD_EN && (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    select_next   = select_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next    = ST_OWN;
          select_next   = pick_idx;
          grant_next    = onehot(pick_idx);
          busy_next     = 1'b1;
          hold_cnt_next = '0;
        end else begin
          // select deliberately keeps its last value while idle.
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end

      ST_OWN: begin
        // New requests are not looked at here: no preemption.
        if (rel_done || rel_withdraw || rel_limit) begin
          state_next   = ST_IDLE;
          grant_next   = '0;
          busy_next    = 1'b0;
          ptr_next     = select_reg + idx_t'(1);
          // done and withdrawal take precedence over the hold limit.
          timeout_next = rel_limit && !rel_done && !rel_withdraw;
        end else if (hold_cnt_reg != CNT_MAX) begin
          hold_cnt_next = hold_cnt_reg + cnt_t'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      select_reg   <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      select_reg   <= select_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.grant   = grant_reg;
  assign bus.select  = select_reg;
  assign bus.busy    = busy_reg;
  assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_mux8_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8_arbiter
// Two arbiters share the same req/done stimulus: unit 0 with MAX_HOLD = 4,
// unit 1 with MAX_HOLD = 0 (no hold limit). A behavioural model tracks the
// owner, pointer and held-cycle count of each and is compared every cycle;
// directed phases add fixed expectations from the scenario descriptions.
// -----------------------------------------------------------------------------
module tb_mux8_arbiter;
  import mux8_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_drv;
  logic       done_drv;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state per unit: owner < 0 means nobody owns the mux.
  int m_owner [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_held  [2];
  bit m_to    [2];

  always #5 clk = ~clk;

  mux8_arbiter_if bus_a ();
  mux8_arbiter_if bus_b ();

  assign bus_a.req  = req_drv;
  assign bus_a.done = done_drv;
  assign bus_b.req  = req_drv;
  assign bus_b.done = done_drv;

  mux8_arbiter #(.MAX_HOLD(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  mux8_arbiter #(.MAX_HOLD(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_sel[u]   = 0;
      m_ptr[u]   = 0;
      m_held[u]  = 0;
      m_to[u]    = 1'b0;
    end
  endtask

  // One clock of the arbitration rules for both units.
  task automatic model_update(input logic [7:0] r, input bit d);
    for (int u = 0; u < 2; u++) begin
      int mh;
      mh = (u == 0) ? 4 : 0;
      m_to[u] = 1'b0;
      if (m_owner[u] < 0) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr[u] + k) % 8;
          if (r[c] && m_owner[u] < 0) begin
            m_owner[u] = c;
            m_sel[u]   = c;
            m_held[u]  = 0;
          end
        end
      end else if (d || !r[m_owner[u]] || (mh != 0 && m_held[u] == mh - 1)) begin
        m_to[u]    = !d && r[m_owner[u]];
        m_ptr[u]   = (m_owner[u] + 1) % 8;
        m_owner[u] = -1;
      end else if (m_held[u] < 255) begin
        m_held[u]++;
      end
    end
  endtask

  function automatic logic [7:0] exp_grant(input int u);
    logic [7:0] one;
    one = 8'h01;
    exp_grant = (m_owner[u] < 0) ? 8'h00 : (one << m_owner[u]);
  endfunction

  task automatic check_model();
    chk("a_grant",   bus_a.grant,             exp_grant(0));
    chk("a_select",  {5'b0, bus_a.select},    8'(m_sel[0]));
    chk("a_busy",    {7'b0, bus_a.busy},      {7'b0, (m_owner[0] >= 0)});
    chk("a_timeout", {7'b0, bus_a.timeout},   {7'b0, m_to[0]});
    chk("b_grant",   bus_b.grant,             exp_grant(1));
    chk("b_select",  {5'b0, bus_b.select},    8'(m_sel[1]));
    chk("b_busy",    {7'b0, bus_b.busy},      {7'b0, (m_owner[1] >= 0)});
    chk("b_timeout", {7'b0, bus_b.timeout},   {7'b0, m_to[1]});
  endtask

  // Apply inputs, clock once, then compare 1 time unit after the edge.
  task automatic step(input logic [7:0] r, input bit d);
    req_drv  = r;
    done_drv = d;
    @(posedge clk);
    model_update(r, d);
    #1;
    $display("[%0t] req=%h done=%b | A grant=%h sel=%0d busy=%b to=%b | B grant=%h sel=%0d busy=%b to=%b",
             $time, r, d, bus_a.grant, bus_a.select, bus_a.busy, bus_a.timeout,
             bus_b.grant, bus_b.select, bus_b.busy, bus_b.timeout);
    check_model();
  endtask

  task automatic apply_reset();
    req_drv  = 8'h00;
    done_drv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_a_grant", bus_a.grant, 8'h00);
    chk("rst_a_busy",  {7'b0, bus_a.busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] one;
    bit         d;
    one      = 8'h01;
    rst_n    = 1'b0;
    req_drv  = 8'h00;
    done_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("reset_grant",   bus_a.grant,              8'h00);
    chk("reset_select",  {5'b0, bus_a.select},     8'h00);
    chk("reset_busy",    {7'b0, bus_a.busy},       8'h00);
    chk("reset_timeout", {7'b0, bus_a.timeout},    8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant.
    step(8'h10, 1'b0);
    chk("pre_rst_grant", bus_a.grant, 8'h10);
    step(8'h10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_a_grant",  bus_a.grant,          8'h00);
    chk("async_rst_a_select", {5'b0, bus_a.select}, 8'h00);
    chk("async_rst_a_busy",   {7'b0, bus_a.busy},   8'h00);
    chk("async_rst_b_grant",  bus_b.grant,          8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h10, 1'b0);
    chk("post_rst_grant",  bus_a.grant,          8'h10);
    chk("post_rst_select", {5'b0, bus_a.select}, 8'h04);
    step(8'h10, 1'b1);

    // Round-robin fairness with every requester active.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      chk("fair_grant_a", bus_a.grant, one << (i % 8));
      chk("fair_grant_b", bus_b.grant, one << (i % 8));
      step(8'hFF, 1'b1);
      chk("fair_dead", bus_a.grant, 8'h00);
    end

    // Pointer wrap: serve 5 so the scan starts at 6.
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    step(8'h21, 1'b0);
    chk("wrap_grant0",  bus_a.grant,          8'h01);
    chk("wrap_select0", {5'b0, bus_a.select}, 8'h00);
    step(8'h21, 1'b1);
    step(8'h21, 1'b0);
    chk("wrap_grant5",  bus_a.grant,          8'h20);
    chk("wrap_select5", {5'b0, bus_a.select}, 8'h05);
    step(8'h21, 1'b1);

    // Timeout: unit A releases after exactly four cycles, unit B holds on.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h08, 1'b0);
      chk("to_hold_grant", bus_a.grant,            8'h08);
      chk("to_hold_pulse", {7'b0, bus_a.timeout},  8'h00);
    end
    step(8'h08, 1'b0);
    chk("to_release_grant", bus_a.grant,           8'h00);
    chk("to_release_pulse", {7'b0, bus_a.timeout}, 8'h01);
    chk("to_nolimit_grant", bus_b.grant,           8'h08);
    step(8'h18, 1'b0);
    chk("to_ptr4_grant",    bus_a.grant,           8'h10);
    chk("to_pulse_clear",   {7'b0, bus_a.timeout}, 8'h00);
    step(8'h18, 1'b1);
    step(8'h00, 1'b0);

    // done coinciding with the hold limit: no timeout pulse.
    apply_reset();
    for (int i = 0; i < 4; i++) step(8'h08, 1'b0);
    step(8'h08, 1'b1);
    chk("done_limit_grant", bus_a.grant,           8'h00);
    chk("done_limit_pulse", {7'b0, bus_a.timeout}, 8'h00);
    // Owner withdraws mid-grant.
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    chk("wd_grant_on", bus_a.grant, 8'h08);
    step(8'h00, 1'b0);
    chk("wd_grant_off", bus_a.grant,           8'h00);
    chk("wd_pulse",     {7'b0, bus_a.timeout}, 8'h00);

    // No preemption: requester 0 arrives while 2 owns the mux.
    apply_reset();
    step(8'h04, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(8'h05, 1'b0);
      chk("nopre_grant",  bus_a.grant,          8'h04);
      chk("nopre_select", {5'b0, bus_a.select}, 8'h02);
    end
    step(8'h05, 1'b1);
    chk("nopre_dead", bus_a.grant, 8'h00);
    step(8'h05, 1'b0);
    chk("nopre_next", bus_a.grant, 8'h01);
    step(8'h05, 1'b1);

    // Long hold without a limit: the saturating counter must never release.
    apply_reset();
    for (int i = 0; i < 270; i++) step(8'h01, 1'b0);
    chk("long_hold_b", bus_b.grant, 8'h01);
    step(8'h01, 1'b1);

    // Randomized traffic against the model.
    apply_reset();
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
      d = ($urandom_range(0, 5) == 0);
      step(r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
